// File: rtl/bfly_addsub.sv
// Radix-2 butterfly add/subtract, two-stage valid/ready pipeline.
// Per-transaction shift-by-one scaling or saturation, sticky overflow.
module bfly_addsub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_re,
  input  logic [W-1:0] a_im,
  input  logic [W-1:0] b_re,
  input  logic [W-1:0] b_im,
  input  logic         scale,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] s_re,
  output logic [W-1:0] s_im,
  output logic [W-1:0] d_re,
  output logic [W-1:0] d_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ovf,
  input  logic         clr_ovf
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         adv;

  logic         s1_vld_q;
  logic         s1_scl_q;
  logic [W:0]   s1_sre_q, s1_sim_q;
  logic [W:0]   s1_dre_q, s1_dim_q;
  logic [W:0]   s1_sre_d, s1_sim_d;
  logic [W:0]   s1_dre_d, s1_dim_d;

  logic         s2_vld_q;
  logic [W-1:0] s2_sre_q, s2_sim_q;
  logic [W-1:0] s2_dre_q, s2_dim_q;
  logic [W-1:0] s2_sre_d, s2_sim_d;
  logic [W-1:0] s2_dre_d, s2_dim_d;

  logic         sat_any;
  logic         ovf_q, ovf_d;

  // Scale: drop the LSB (floor). Otherwise clamp when the
  // two top bits disagree, i.e. the sum left the W-bit range.
  function automatic logic [W-1:0] post(
    input logic [W:0] r,
    input logic       scl
  );
    logic [W-1:0] v;
    if (scl)
      v = r[W:1];
    else if (r[W] ^ r[W-1])
      v = r[W] ? MINV : MAXV;
    else
      v = r[W-1:0];
    return v;
  endfunction

  assign adv      = !s2_vld_q || out_ready;
  assign in_ready = adv;

  // Full-precision sums and differences, one guard bit wide
  always_comb begin
    s1_sre_d = {a_re[W-1], a_re} + {b_re[W-1], b_re};
    s1_sim_d = {a_im[W-1], a_im} + {b_im[W-1], b_im};
    s1_dre_d = {a_re[W-1], a_re} - {b_re[W-1], b_re};
    s1_dim_d = {a_im[W-1], a_im} - {b_im[W-1], b_im};
  end

  // Narrow S1 results to W bits and flag any clamp
  always_comb begin
    s2_sre_d = post(s1_sre_q, s1_scl_q);
    s2_sim_d = post(s1_sim_q, s1_scl_q);
    s2_dre_d = post(s1_dre_q, s1_scl_q);
    s2_dim_d = post(s1_dim_q, s1_scl_q);
    sat_any  = !s1_scl_q &&
               ((s1_sre_q[W] ^ s1_sre_q[W-1]) ||
                (s1_sim_q[W] ^ s1_sim_q[W-1]) ||
                (s1_dre_q[W] ^ s1_dre_q[W-1]) ||
                (s1_dim_q[W] ^ s1_dim_q[W-1]));
  end

  // Sticky overflow: a new saturation wins over a clear
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf)
      ovf_d = 1'b0;
    if (adv && s1_vld_q && sat_any)
      ovf_d = 1'b1;
  end

  // Stage 1: capture operands when the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_scl_q <= 1'b0;
      s1_sre_q <= '0;
      s1_sim_q <= '0;
      s1_dre_q <= '0;
      s1_dim_q <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      s1_scl_q <= scale;
      s1_sre_q <= s1_sre_d;
      s1_sim_q <= s1_sim_d;
      s1_dre_q <= s1_dre_d;
      s1_dim_q <= s1_dim_d;
    end
  end

  // Stage 2: output registers, frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_sre_q <= '0;
      s2_sim_q <= '0;
      s2_dre_q <= '0;
      s2_dim_q <= '0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      s2_sre_q <= s2_sre_d;
      s2_sim_q <= s2_sim_d;
      s2_dre_q <= s2_dre_d;
      s2_dim_q <= s2_dim_d;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign out_valid = s2_vld_q;
  assign s_re      = s2_sre_q;
  assign s_im      = s2_sim_q;
  assign d_re      = s2_dre_q;
  assign d_im      = s2_dim_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bfly_addsub.sv
// Randomized bench for bfly_addsub against an integer model.
// Directed butterfly, saturation, scaling, stall and reset cases.
module tb_bfly_addsub;

  localparam int W  = 16;
  localparam int MX = 32767;
  localparam int MN = -32768;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a_re = '0, a_im = '0;
  logic [W-1:0] b_re = '0, b_im = '0;
  logic         scale = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] s_re, s_im, d_re, d_im;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         ovf;
  logic         clr_ovf = 1'b0;

  always #5 clk = ~clk;

  bfly_addsub #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .scale    (scale),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_re     (s_re),
    .s_im     (s_im),
    .d_re     (d_re),
    .d_im     (d_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  typedef struct {
    int are, aim, bre, bim;
    bit scl;
    bit lat;
  } txn_t;

  typedef struct {
    int sre, sim, dre, dim;
    bit sat;
    bit lat;
    int acc;
  } res_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  txn_t stim_q[$];
  res_t exp_q[$];
  bit   ovf_m = 0;
  bit   bubbles = 0;
  bit   rnd_rdy = 0;
  bit   accepted = 0;
  bit   stall_prev = 0;
  int   stall_lo = -1;
  int   stall_hi = -2;
  int   hold[4];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int post(input int r, input bit scl,
                              inout bit sat);
    if (scl)
      return (r < 0 && (r % 2) != 0) ? (r - 1) / 2 : r / 2;
    if (r > MX) begin
      sat = 1'b1;
      return MX;
    end
    if (r < MN) begin
      sat = 1'b1;
      return MN;
    end
    return r;
  endfunction

  function automatic res_t model(input txn_t t, input int c);
    res_t e;
    e.sat = 1'b0;
    e.sre = post(t.are + t.bre, t.scl, e.sat);
    e.sim = post(t.aim + t.bim, t.scl, e.sat);
    e.dre = post(t.are - t.bre, t.scl, e.sat);
    e.dim = post(t.aim - t.bim, t.scl, e.sat);
    e.lat = t.lat;
    e.acc = c;
    return e;
  endfunction

  function automatic int rv();
    case ($urandom_range(3))
      0:       return MX;
      1:       return MN;
      default: return int'($urandom_range(65535)) - 32768;
    endcase
  endfunction

  task automatic push(input int ar, input int ai, input int br,
                      input int bi, input bit sc, input bit lt);
    txn_t t;
    t.are = ar; t.aim = ai; t.bre = br; t.bim = bi;
    t.scl = sc; t.lat = lt;
    stim_q.push_back(t);
  endtask

  task automatic cycle();
    int   o[4];
    res_t e;
    @(negedge clk);
    cyc++;
    if (accepted) begin
      in_valid = 1'b0;
      accepted = 1'b0;
    end
    if (!in_valid && stim_q.size() > 0 &&
        (!bubbles || $urandom_range(3) != 0)) begin
      in_valid = 1'b1;
      a_re  = W'(stim_q[0].are);
      a_im  = W'(stim_q[0].aim);
      b_re  = W'(stim_q[0].bre);
      b_im  = W'(stim_q[0].bim);
      scale = stim_q[0].scl;
    end
    if (rnd_rdy)
      out_ready = ($urandom_range(9) < 7);
    else
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    #4;
    o[0] = int'($signed(s_re));
    o[1] = int'($signed(s_im));
    o[2] = int'($signed(d_re));
    o[3] = int'($signed(d_im));
    chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
    if (stall_prev) begin
      chk("stall_valid", int'(out_valid), 1);
      for (int i = 0; i < 4; i++)
        chk("stall_hold", o[i], hold[i]);
    end
    if (exp_q.size() == 0) begin
      chk("no_extra", int'(out_valid), 0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      ovf_m |= e.sat;
      chk("s_re", o[0], e.sre);
      chk("s_im", o[1], e.sim);
      chk("d_re", o[2], e.dre);
      chk("d_im", o[3], e.dim);
      chk("ovf", int'(ovf), int'(ovf_m));
      if (e.lat)
        chk("latency", cyc - e.acc, 2);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(stim_q.pop_front(), cyc));
      accepted = 1'b1;
    end
    stall_prev = out_valid && !out_ready;
    for (int i = 0; i < 4; i++)
      hold[i] = o[i];
  endtask

  task automatic drain();
    int n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 5000) begin
      cycle();
      n++;
    end
    if (n >= 5000)
      chk("drain_timeout", exp_q.size() + stim_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_s_re", int'(s_re), 0);
    chk("rst_s_im", int'(s_im), 0);
    chk("rst_d_re", int'(d_re), 0);
    chk("rst_d_im", int'(d_im), 0);
    stim_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
    accepted = 1'b0;
    stall_prev = 1'b0;
    ovf_m = 1'b0;
    stall_lo = -1;
    stall_hi = -2;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_valid", int'(out_valid), 0);
    chk("init_ready", int'(in_ready), 1);
    chk("init_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push(100, -50, 30, 20, 1'b0, 1'b1);
    drain();

    push(32767, -32768, 1, 1, 1'b0, 1'b1);
    drain();
    repeat (3) cycle();
    chk("ovf_sticky", int'(ovf), 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    ovf_m = 1'b0;
    #1;
    chk("ovf_clr", int'(ovf), 0);

    push(32767, -3, 32767, 0, 1'b1, 1'b1);
    drain();

    stall_lo = cyc + 5;
    stall_hi = cyc + 7;
    for (int i = 0; i < 8; i++)
      push(rv(), rv(), rv(), rv(), 1'($urandom_range(1)), 1'b0);
    drain();
    stall_lo = -1;
    stall_hi = -2;

    push(32767, 0, 5, 0, 1'b0, 1'b0);
    stall_lo = cyc + 1;
    stall_hi = cyc + 100;
    repeat (4) cycle();
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_ovf", int'(ovf), 1);
    do_reset();

    push(1000, 2000, 3000, 4000, 1'b0, 1'b0);
    push(-7, 9, 11, -13, 1'b1, 1'b0);
    repeat (2) cycle();
    do_reset();
    push(1, 1, 2, 2, 1'b0, 1'b1);
    drain();

    bubbles = 1'b1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++)
      push(rv(), rv(), rv(), rv(), 1'($urandom_range(1)), 1'b0);
    drain();
    bubbles = 1'b0;
    rnd_rdy = 1'b0;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bfly_addsub.md
BFLY_ADDSUB -- requirements
Module: bfly_addsub

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the signed two's-complement width of each real/imag component.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have ports a_re, a_im, b_re, b_im  input  W each  butterfly operands A and B, signed.
REQ-005 The block SHALL have port scale  input  1  per-transaction select: 1 = arithmetic shift right by 1, 0 = saturate.
REQ-006 The block SHALL have port in_valid  input  1  operands and scale valid this cycle.
REQ-007 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 The block SHALL have ports s_re, s_im, d_re, d_im  output  W each  results A+B and A-B.
REQ-009 The block SHALL have port out_valid  output  1  results valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts results.
REQ-011 The block SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 The block SHALL have port clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-013 The block SHALL accept a transaction on a rising edge where in_valid=1 and in_ready=1.
REQ-014 The block SHALL have two register stages, S1 and S2, each with a valid bit; S2 drives the outputs.
REQ-015 S1 SHALL register the four full-precision results at width W+1, sign-extended: a_re+b_re, a_im+b_im, a_re-b_re, a_im-b_im, plus scale.
REQ-016 S2 SHALL post-process each W+1 result r as follows.
- scale=1: output r[W:1], an arithmetic shift right, rounding toward minus infinity.
- scale=0 and r in range: output r[W-1:0].
- scale=0 and r > 2^(W-1)-1: output 2^(W-1)-1.
- scale=0 and r < -2^(W-1): output -2^(W-1).
REQ-017 The pipeline advance enable SHALL be adv = !out_valid || out_ready, and in_ready SHALL equal adv, combinationally.
REQ-018 When adv=1, S1 SHALL load the input (valid bit = in_valid) and S2 SHALL load S1 (valid bit = S1 valid). When adv=0, both stages SHALL hold.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held at 1; throughput SHALL be one transaction per cycle.
REQ-020 While out_valid=1 and out_ready=0, all outputs SHALL be held stable and no transaction SHALL be lost or duplicated.
REQ-021 ovf SHALL set on the cycle S2 loads a valid transaction with scale=0 in which any of the four components saturated. It SHALL stay set until cleared.
REQ-022 clr_ovf=1 SHALL clear ovf on the next edge; if a new saturation occurs in the same cycle, set SHALL take priority.
REQ-023 Stage data registers SHALL load only when adv=1, so outputs never change while the output is stalled.
REQ-024 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid stages; no bubble compression is required.

Reset
REQ-025 rst_n=0 SHALL immediately clear the S1 valid bit, the S2 valid bit, ovf, and all data registers to 0, independent of clk. As a result out_valid=0 and s/d outputs=0, and in_ready=1 while in reset.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight transactions. The first transaction accepted after rst_n rises SHALL appear 2 cycles later with no stale data.

Verification
REQ-027 Reset check: assert rst_n=0 between clock edges -> out_valid, ovf and all outputs are 0 at once, and in_ready=1.
REQ-028 Basic butterfly: A=(100,-50), B=(30,20), scale=0, out_ready=1 -> 2 cycles later s=(130,-30), d=(70,-70), ovf=0.
REQ-029 Saturation: A=(32767,-32768), B=(1,1), scale=0 -> s=(32767,-32767), d=(32766,-32768); ovf=1 stays set until clr_ovf pulses, then reads 0.
REQ-030 Scaling: A=(32767,-3), B=(32767,0), scale=1 -> s=(32767,-2), d=(0,-2); ovf unchanged.
REQ-031 Backpressure: stream 8 back-to-back transactions with out_ready low for 3 cycles mid-stream -> outputs are stable while stalled, in_ready=0 while stalled, and all 8 results arrive in order exactly once.
REQ-032 Reset mid-stream: assert rst_n with 2 transactions in flight -> neither appears; a new transaction A=(1,1), B=(2,2) yields s=(3,3), d=(-1,-1) 2 cycles after acceptance.
